// File: rtl/mult_core_fp6.sv
// mult_core_fp6: LANES-wide FP6 (E2M3, bias 1) multiplier front end.
// Stage 1 decodes the operands into sign, significand and effective exponent.
// Stage 2 forms the raw significand product and exponent for the normalizer.
// The two stages form a valid/ready pipeline with backpressure. A saturating
// counter records accepted outputs that have any overflowed lane.
module mult_core_fp6 #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*6-1:0]   in_a,
  input  logic [LANES*6-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES-1:0]     out_sign,
  output logic [LANES*3-1:0]   out_e,
  output logic [LANES*8-1:0]   out_m,
  output logic [LANES-1:0]     out_zero,
  output logic [CNT_W-1:0]     ovf_cnt,
  input  logic                 cnt_clr
);

  // Pipeline occupancy and handshake control
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_load, s2_load, out_xfer;

  // Stage 1 registers (decoded operands)
  logic [LANES-1:0]   s1_sign_q, s1_zero_q;
  logic [LANES*4-1:0] s1_sig_a_q, s1_sig_b_q;
  logic [LANES*2-1:0] s1_eff_a_q, s1_eff_b_q;

  // Stage 2 registers (products)
  logic [LANES-1:0]   out_sign_q, out_zero_q;
  logic [LANES*3-1:0] out_e_q;
  logic [LANES*8-1:0] out_m_q;

  // Overflow event counter
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // Per-lane combinational results
  logic [LANES-1:0]   dec_sign, dec_zero;
  logic [LANES*4-1:0] dec_sig_a, dec_sig_b;
  logic [LANES*2-1:0] dec_eff_a, dec_eff_b;
  logic [LANES*3-1:0] mul_e;
  logic [LANES*8-1:0] mul_m;
  logic [LANES-1:0]   lane_ovf;

  // Stage 2 refills whenever it is empty or its content leaves this cycle,
  // so an empty stage 2 always pulls stage 1 forward (bubbles collapse).
  assign s2_load  = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_load;
  assign s1_load  = in_valid & in_ready;
  assign out_xfer = s2_valid_q & out_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [5:0] a_l, b_l;
      logic [7:0] prod;
      logic [2:0] e_sum;

      assign a_l = in_a[6*gi +: 6];
      assign b_l = in_b[6*gi +: 6];

      // Decode: hidden bit set for normals; subnormals share exponent 1.
      assign dec_sign[gi]          = a_l[5] ^ b_l[5];
      assign dec_sig_a[4*gi +: 4]  = {|a_l[4:3], a_l[2:0]};
      assign dec_sig_b[4*gi +: 4]  = {|b_l[4:3], b_l[2:0]};
      assign dec_eff_a[2*gi +: 2]  = (a_l[4:3] == 2'b00) ? 2'd1 : a_l[4:3];
      assign dec_eff_b[2*gi +: 2]  = (b_l[4:3] == 2'b00) ? 2'd1 : b_l[4:3];
      assign dec_zero[gi]          = (a_l[4:0] == 5'd0) | (b_l[4:0] == 5'd0);

      // Multiply: a product >= 2.0 is shifted right and bumps the exponent.
      // Minimum exponent sum is 1+1-1=1, maximum 3+3-1+1=6, so 3 bits suffice.
      assign prod  = {4'b0, s1_sig_a_q[4*gi +: 4]} * {4'b0, s1_sig_b_q[4*gi +: 4]};
      assign e_sum = {1'b0, s1_eff_a_q[2*gi +: 2]} + {1'b0, s1_eff_b_q[2*gi +: 2]}
                     - 3'd1 + {2'b0, prod[7]};
      assign mul_m[8*gi +: 8] = s1_zero_q[gi] ? 8'd0 : (prod[7] ? {1'b0, prod[7:1]} : prod);
      assign mul_e[3*gi +: 3] = s1_zero_q[gi] ? 3'd0 : e_sum;

      // Exponent bit 2 flags overflow; zero lanes never count.
      assign lane_ovf[gi] = out_e_q[3*gi+2] & ~out_zero_q[gi];
    end
  endgenerate

  // Next-state for stage valid bits and the saturating counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (in_ready) s1_valid_d = in_valid;
    if (s2_load)  s2_valid_d = s1_valid_q;
    if (cnt_clr) begin
      ovf_cnt_d = '0;
    end else if (out_xfer && (|lane_ovf) && !(&ovf_cnt_q)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  // Stage 1 register: capture decoded operands on input transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= '0;
      s1_zero_q  <= '0;
      s1_sig_a_q <= '0;
      s1_sig_b_q <= '0;
      s1_eff_a_q <= '0;
      s1_eff_b_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_sign_q  <= dec_sign;
        s1_zero_q  <= dec_zero;
        s1_sig_a_q <= dec_sig_a;
        s1_sig_b_q <= dec_sig_b;
        s1_eff_a_q <= dec_eff_a;
        s1_eff_b_q <= dec_eff_b;
      end
    end
  end

  // Stage 2 register: capture products; holds while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_sign_q <= '0;
      out_zero_q <= '0;
      out_e_q    <= '0;
      out_m_q    <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load && s1_valid_q) begin
        out_sign_q <= s1_sign_q;
        out_zero_q <= s1_zero_q;
        out_e_q    <= mul_e;
        out_m_q    <= mul_m;
      end
    end
  end

  // Overflow counter register
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = out_sign_q;
  assign out_zero  = out_zero_q;
  assign out_e     = out_e_q;
  assign out_m     = out_m_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_mult_core_fp6.sv
// Testbench for mult_core_fp6: directed vectors, back-to-back streaming,
// random backpressure against a value-level reference model, reset flush,
// and counter saturation / clear priority.
module tb_mult_core_fp6;
  localparam int LANES = 4;
  localparam int CNT_W = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [LANES*6-1:0]   in_a = '0;
  logic [LANES*6-1:0]   in_b = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [LANES-1:0]     out_sign;
  logic [LANES*3-1:0]   out_e;
  logic [LANES*8-1:0]   out_m;
  logic [LANES-1:0]     out_zero;
  logic [CNT_W-1:0]     ovf_cnt;
  logic                 cnt_clr = 1'b0;

  typedef struct packed {
    logic [LANES-1:0]   sign;
    logic [LANES*3-1:0] e;
    logic [LANES*8-1:0] m;
    logic [LANES-1:0]   zero;
  } prod_t;

  prod_t obs;
  assign obs = {out_sign, out_e, out_m, out_zero};

  int n_cmp = 0;
  int n_bad = 0;
  int ovf_model = 0;
  int cnt_max = (1 << CNT_W) - 1;

  mult_core_fp6 #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_e(out_e), .out_m(out_m), .out_zero(out_zero),
    .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  // Reference: real significands (hidden bit included) multiplied as integers,
  // renormalised into [1,2) by halving with an exponent bump.
  function automatic prod_t ref_vec(input logic [LANES*6-1:0] a, input logic [LANES*6-1:0] b);
    prod_t r;
    int ea, eb, sa, sb, p, e, m;
    logic [5:0] la, lb;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      la = a[6*l +: 6];
      lb = b[6*l +: 6];
      ea = int'(la[4:3]);
      eb = int'(lb[4:3]);
      sa = (ea == 0) ? int'(la[2:0]) : 8 + int'(la[2:0]);
      sb = (eb == 0) ? int'(lb[2:0]) : 8 + int'(lb[2:0]);
      if (ea == 0) ea = 1;
      if (eb == 0) eb = 1;
      r.sign[l] = la[5] ^ lb[5];
      if (la[4:0] == 5'd0 || lb[4:0] == 5'd0) begin
        r.zero[l] = 1'b1;
      end else begin
        p = sa * sb;
        if (p >= 128) begin m = p / 2; e = ea + eb;     end
        else          begin m = p;     e = ea + eb - 1; end
        r.e[3*l +: 3] = 3'(e);
        r.m[8*l +: 8] = 8'(m);
      end
    end
    return r;
  endfunction

  function automatic bit any_ovf(input prod_t p);
    for (int l = 0; l < LANES; l++)
      if (!p.zero[l] && p.e[3*l+2]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [LANES*6-1:0] rand_vec();
    logic [LANES*6-1:0] v;
    for (int l = 0; l < LANES; l++) v[6*l +: 6] = 6'($urandom_range(0, 63));
    return v;
  endfunction

  function automatic void model_xfer(input prod_t p);
    if (any_ovf(p) && ovf_model < cnt_max) ovf_model++;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    ovf_model = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (obs !== prod_t'(0)) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
    n_cmp++; if (ovf_cnt !== '0) begin n_bad++; $display("FAIL reset_ovf_cnt: got %0d want 0", ovf_cnt); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    $display("test_reset done");
  endtask

  // Lane 0 directed vectors; other lanes are zero so they never overflow.
  task automatic test_directed();
    logic [5:0] ta [5] = '{6'h0A, 6'h1F, 6'h3F, 6'h01, 6'h20};
    logic [5:0] tb [5] = '{6'h0C, 6'h1F, 6'h1F, 6'h08, 6'h1F};
    logic       ts [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] te [5] = '{3'd1, 3'd6, 3'd6, 3'd1, 3'd0};
    logic [7:0] tm [5] = '{8'h78, 8'h70, 8'h70, 8'h08, 8'h00};
    logic       tz [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    prod_t exp_p;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a = '0; in_b = '0;
      in_a[5:0] = ta[i];
      in_b[5:0] = tb[i];
      exp_p = ref_vec(in_a, in_b);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_latency1: out_valid %b want 0", i, out_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dir%0d_latency2: out_valid %b want 1", i, out_valid); end
      n_cmp++;
      if (out_sign[0] !== ts[i] || out_e[2:0] !== te[i] || out_m[7:0] !== tm[i] || out_zero[0] !== tz[i]) begin
        n_bad++;
        $display("FAIL dir%0d_lane0: got s=%b e=%0d m=%h z=%b want s=%b e=%0d m=%h z=%b",
                 i, out_sign[0], out_e[2:0], out_m[7:0], out_zero[0], ts[i], te[i], tm[i], tz[i]);
      end
      n_cmp++; if (obs !== exp_p) begin n_bad++; $display("FAIL dir%0d_vector: got %h want %h", i, obs, exp_p); end
      model_xfer(exp_p);
      tick();
      n_cmp++; if (ovf_cnt !== CNT_W'(ovf_model)) begin n_bad++; $display("FAIL dir%0d_ovf_cnt: got %0d want %0d", i, ovf_cnt, ovf_model); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_drained: out_valid %b want 0", i, out_valid); end
      $display("directed %0d: a=%h b=%h -> s=%b e=%0d m=%h z=%b ovf_cnt=%0d", i, ta[i], tb[i],
               out_sign[0], te[i], tm[i], tz[i], ovf_cnt);
    end
  endtask

  task automatic test_back_to_back();
    prod_t q[$];
    prod_t exp_p;
    clear_cnt();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 6);
      in_a = rand_vec();
      in_b = rand_vec();
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, in_ready); end
      n_cmp++; if (out_valid !== (c >= 2)) begin n_bad++; $display("FAIL b2b_out_valid c%0d: got %b want %b", c, out_valid, (c >= 2)); end
      if (out_valid && q.size() > 0) begin
        exp_p = q.pop_front();
        n_cmp++; if (obs !== exp_p) begin n_bad++; $display("FAIL b2b_data c%0d: got %h want %h", c, obs, exp_p); end
        model_xfer(exp_p);
      end
      if (in_valid) q.push_back(ref_vec(in_a, in_b));
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL b2b_leftover: got %0d want 0", q.size()); end
    n_cmp++; if (ovf_cnt !== CNT_W'(ovf_model)) begin n_bad++; $display("FAIL b2b_ovf_cnt: got %0d want %0d", ovf_cnt, ovf_model); end
    $display("test_back_to_back done: ovf_cnt=%0d", ovf_cnt);
  endtask

  task automatic test_stream();
    prod_t q[$];
    prod_t prev_obs, exp_p;
    logic  prev_stall = 1'b0;
    logic  exp_ready;
    int    sent = 0, recv = 0, cyc = 0;
    clear_cnt();
    in_valid = 1'b0;
    while (recv < 8 && cyc < 400) begin
      n_cmp++; if (ovf_cnt !== CNT_W'(ovf_model)) begin n_bad++; $display("FAIL stream_ovf_cnt cyc%0d: got %0d want %0d", cyc, ovf_cnt, ovf_model); end
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin
          n_bad++; $display("FAIL stream_stable cyc%0d: got v=%b %h want v=1 %h", cyc, out_valid, obs, prev_obs);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && sent < 8 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_a = rand_vec();
        in_b = rand_vec();
      end
      #1;
      exp_ready = !(q.size() == 2 && !out_ready);
      n_cmp++; if (in_ready !== exp_ready) begin n_bad++; $display("FAIL stream_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_ready); end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL stream_spurious cyc%0d: got output %h want none", cyc, obs);
        end else begin
          exp_p = q.pop_front();
          n_cmp++; if (obs !== exp_p) begin n_bad++; $display("FAIL stream_data #%0d: got %h want %h", recv, obs, exp_p); end
          model_xfer(exp_p);
          $display("stream out #%0d at cyc %0d: %h", recv, cyc, obs);
          recv++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_obs   = obs;
      if (in_valid && in_ready) begin
        q.push_back(ref_vec(in_a, in_b));
        sent++;
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (recv != 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8 (timeout)", recv); end
    out_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_duplicate: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_inflight();
    clear_cnt();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = {LANES{6'h1F}}; in_b = {LANES{6'h1F}};
    tick();
    in_a = {LANES{6'h3F}};
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL inflight_full: got v=%b r=%b want v=1 r=0", out_valid, in_ready); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL inflight_flush: out_valid %b want 0", out_valid); end
    n_cmp++; if (ovf_cnt !== '0) begin n_bad++; $display("FAIL inflight_ovf: got %0d want 0", ovf_cnt); end
    n_cmp++; if (obs !== prod_t'(0)) begin n_bad++; $display("FAIL inflight_outputs: got %h want 0", obs); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    ovf_model = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0 || ovf_cnt !== '0) begin n_bad++; $display("FAIL inflight_ghost c%0d: got v=%b cnt=%0d want v=0 cnt=0", c, out_valid, ovf_cnt); end
    end
    $display("test_reset_inflight done");
  endtask

  task automatic test_saturate();
    int xfers = 0;
    int want;
    clear_cnt();
    out_ready = 1'b1;
    in_a = {LANES{6'h1F}}; in_b = {LANES{6'h1F}};
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 5);
      #1;
      if (out_valid && out_ready) xfers++;
      tick();
      want = (xfers > cnt_max) ? cnt_max : xfers;
      n_cmp++; if (ovf_cnt !== CNT_W'(want)) begin n_bad++; $display("FAIL sat_cnt c%0d: got %0d want %0d", c, ovf_cnt, want); end
    end
    n_cmp++; if (ovf_cnt !== CNT_W'(cnt_max)) begin n_bad++; $display("FAIL sat_hold: got %0d want %0d", ovf_cnt, cnt_max); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_setup: out_valid %b want 1", out_valid); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_cmp++; if (ovf_cnt !== '0) begin n_bad++; $display("FAIL clr_priority: got %0d want 0", ovf_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_xfer: out_valid %b want 0", out_valid); end
    $display("test_saturate done: ovf_cnt=%0d", ovf_cnt);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stream();
    test_reset_inflight();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
